// File: rtl/n3_b2_divider.sv
// 3-bit unsigned restoring divider built on a ripple borrow subtractor.
// Define DIV_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE with div_zero set.

module n3_b2_subtractor (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       bin,
  output logic [2:0] diff,
  output logic       bout
);

  logic [3:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < 3; i++) begin : g_stage
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign bout = borrow[3];

endmodule

module n3_b2_divider (
  input  logic       clock,
  input  logic       reset_,
  input  logic       start,
  input  logic [2:0] dividend,
  input  logic [2:0] divisor,
  output logic [2:0] quotient,
  output logic [2:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] quot_q, quot_d;
  logic [2:0] rem_q, rem_d;
  logic [2:0] dsr_q, dsr_d;
  logic [2:0] sub_diff;
  logic       sub_bout;

  // bout=1 means the running remainder is already smaller than the divisor.
  n3_b2_subtractor u_sub (
    .a    (rem_q),
    .b    (dsr_q),
    .bin  (1'b0),
    .diff (sub_diff),
    .bout (sub_bout)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          rem_d   = dividend;
          dsr_d   = divisor;
          quot_d  = 3'd0;
          state_d = StCalc;
`ifdef DIV_ZERO_CHECK_EN
          dz_d    = 1'b0;
          if (divisor == 3'd0) begin
            quot_d  = 3'd7;
            dz_d    = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        // The saturation guard also bounds a zero divisor to eight cycles.
        if (sub_bout || (quot_q == 3'd7)) begin
          state_d = StDone;
        end else begin
          rem_d  = sub_diff;
          quot_d = quot_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= StIdle;
      quot_q  <= 3'd0;
      rem_q   <= 3'd0;
      dsr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clock) begin
    if (!reset_) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end

  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_n3_b2_divider.sv
// Self-checking bench for n3_b2_divider: arithmetic reference model plus directed vectors.

module tb_n3_b2_divider;

  logic       clock;
  logic       reset_;
  logic       start;
  logic [2:0] dividend;
  logic [2:0] divisor;
  logic [2:0] quotient;
  logic [2:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  n3_b2_divider dut (
    .clock     (clock),
    .reset_    (reset_),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference results from plain arithmetic.
  function automatic int ref_q(input int a, input int b);
    int q;
    if (b == 0) return 7;
    q = a / b;
    return (q > 7) ? 7 : q;
  endfunction

  function automatic int ref_lat(input int a, input int b);
`ifdef DIV_ZERO_CHECK_EN
    if (b == 0) return 1;
`endif
    return ref_q(a, b) + 1;
  endfunction

  function automatic bit ref_dz(input int b);
`ifdef DIV_ZERO_CHECK_EN
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Model state: what the outputs must be after each edge.
  bit       m_busy, m_done, m_dz, m_fdz;
  int       m_cnt;
  int       m_q, m_r, m_fq, m_fr;

  always @(posedge clock) begin
    if (!reset_) begin
      m_busy <= 0; m_done <= 0; m_cnt <= 0;
      m_q <= 0; m_r <= 0; m_dz <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1;
        m_done <= 0;
        m_cnt  <= ref_lat(int'(dividend), int'(divisor));
        m_fq   <= ref_q(int'(dividend), int'(divisor));
        m_fr   <= int'(dividend) - ref_q(int'(dividend), int'(divisor)) * int'(divisor);
        m_fdz  <= ref_dz(int'(divisor));
        m_q    <= 0;
        m_r    <= int'(dividend);
        m_dz   <= 0;
      end
    end else if (m_done) begin
      m_busy <= 0;
      m_done <= 0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1;
        m_q    <= m_fq;
        m_r    <= m_fr;
        m_dz   <= m_fdz;
      end
    end
  end

  // Results are only defined outside the iterating phase.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", {7'd0, busy}, {7'd0, m_busy});
      chk("done", {7'd0, done}, {7'd0, m_done});
      if (!m_busy || m_done) begin
        chk("quotient", {5'd0, quotient}, 8'(m_q));
        chk("remainder", {5'd0, remainder}, 8'(m_r));
        chk("div_zero", {7'd0, div_zero}, {7'd0, m_dz});
      end
    end
  end

  task automatic wait_done(input int e0, input int exp_e, input logic [2:0] eq,
                           input logic [2:0] er, input bit edz, input string nm);
    int e;
    bit got;
    e   = e0;
    got = 0;
    while (!got && e < e0 + 20) begin
      @(posedge clock);
      e++;
      #1;
      if (done === 1'b1) got = 1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s done_timeout: got no done expected edge %0d", nm, exp_e);
    end else begin
      chk({nm, " done_edge"}, 8'(e), 8'(exp_e));
      chk({nm, " q"}, {5'd0, quotient}, {5'd0, eq});
      chk({nm, " r"}, {5'd0, remainder}, {5'd0, er});
      chk({nm, " dz"}, {7'd0, div_zero}, {7'd0, edz});
    end
  endtask

  // Start is sampled at the edge following this call (edge 0).
  task automatic launch(input logic [2:0] a, input logic [2:0] b);
    @(posedge clock);
    #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = 3'($urandom);
    divisor  = 3'($urandom);
  endtask

  task automatic do_div(input logic [2:0] a, input logic [2:0] b, input int exp_e,
                        input logic [2:0] eq, input logic [2:0] er, input bit edz,
                        input string nm);
    launch(a, b);
    wait_done(0, exp_e, eq, er, edz, nm);
  endtask

  initial begin
    reset_   = 1'b0;
    start    = 1'b0;
    dividend = 3'd0;
    divisor  = 3'd0;
    @(posedge clock);
    #1;
    chk_en = 1;
    @(posedge clock);
    #1;
    chk("rst busy", {7'd0, busy}, 8'd0);
    chk("rst q", {5'd0, quotient}, 8'd0);
    chk("rst r", {5'd0, remainder}, 8'd0);
    reset_ = 1'b1;

    do_div(3'd7, 3'd2, 4, 3'd3, 3'd1, 1'b0, "7/2");
    do_div(3'd5, 3'd7, 1, 3'd0, 3'd5, 1'b0, "5/7");
    do_div(3'd7, 3'd1, 8, 3'd7, 3'd0, 1'b0, "7/1");
`ifdef DIV_ZERO_CHECK_EN
    do_div(3'd6, 3'd0, 1, 3'd7, 3'd6, 1'b1, "6/0");
`else
    do_div(3'd6, 3'd0, 8, 3'd7, 3'd6, 1'b0, "6/0");
`endif
    do_div(3'd0, 3'd3, 1, 3'd0, 3'd0, 1'b0, "0/3");

    // Second start at edge 2 must be ignored.
    launch(3'd6, 3'd3);
    @(posedge clock);
    #1;
    dividend = 3'd7;
    divisor  = 3'd1;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(2, 3, 3'd2, 3'd0, 1'b0, "busy_start");
    // Accepted on the cycle right after done.
    do_div(3'd6, 3'd2, 4, 3'd3, 3'd0, 1'b0, "after_done");

    // Reset sampled at edge 3 aborts the division.
    launch(3'd7, 3'd1);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_ = 1'b0;
    @(posedge clock);
    #1;
    chk("abort busy", {7'd0, busy}, 8'd0);
    chk("abort done", {7'd0, done}, 8'd0);
    chk("abort q", {5'd0, quotient}, 8'd0);
    chk("abort r", {5'd0, remainder}, 8'd0);
    chk("abort dz", {7'd0, div_zero}, 8'd0);
    reset_ = 1'b1;
    do_div(3'd4, 3'd2, 3, 3'd2, 3'd0, 1'b0, "4/2");

    repeat (3) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/n3_b2_divider.md
N3_B2_DIVIDER -- requirements
Module: n3_b2_divider

Interface
REQ-001 The block SHALL have the port `clock`, input, width 1: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset_`, input, width 1: synchronous, active-low reset.
REQ-003 The block SHALL have the port `start`, input, width 1: request for a new division; sampled only in IDLE.
REQ-004 The block SHALL have the port `dividend`, input, width 3: unsigned dividend; sampled with `start`.
REQ-005 The block SHALL have the port `divisor`, input, width 3: unsigned divisor; sampled with `start`.
REQ-006 The block SHALL have the port `quotient`, output, width 3: registered quotient.
REQ-007 The block SHALL have the port `remainder`, output, width 3: registered remainder.
REQ-008 The block SHALL have the port `busy`, output, width 1: high whenever state is not IDLE.
REQ-009 The block SHALL have the port `done`, output, width 1: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have the port `div_zero`, output, width 1: divisor-was-zero flag; see REQ-024.

Function
REQ-011 The block SHALL compute `remainder - divisor` with one instance of the existing 3-digit base-2 ripple subtractor, with `bin` tied to 0.
- Its difference output is the candidate remainder.
- Its `bout` output means remainder < divisor.
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE, `start`=1 SHALL, at the clock edge, load the operands and clear the result, then move to CALC.
- Operand load: remainder <- `dividend`, internal divisor register <- `divisor`.
- Result clear: quotient <- 0, `div_zero` <- 0.
REQ-014 In CALC, if subtractor `bout`=1 or quotient=7, the FSM SHALL move to DONE without updating quotient or remainder.
REQ-015 In CALC, if neither REQ-014 condition holds, the block SHALL set remainder <- difference and quotient <- quotient+1, and stay in CALC.
REQ-016 In DONE, `done` SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-017 `quotient`, `remainder` and `div_zero` SHALL hold their values from DONE until the next accepted `start`.
REQ-018 With start accepted at edge 0, the FSM SHALL enter DONE at edge q+1 and `done` SHALL be high between edges q+1 and q+2.
- q is the final quotient.
- For divisor=0 without the macro, DONE is entered at edge 8.
REQ-019 `start` SHALL be ignored while `busy`=1; `dividend` and `divisor` SHALL be don't-care outside the sampling edge.
REQ-020 The quotient SHALL saturate at 7 and never wrap; the quotient=7 guard SHALL bound CALC to at most 8 cycles.

Reset
REQ-021 `reset_`=0 at a rising edge SHALL force IDLE and clear `quotient`, `remainder`, `busy`, `done`, `div_zero` and the internal divisor register to 0.
REQ-022 Reset SHALL take priority over `start` and over every FSM transition, including mid-CALC and in DONE.
- An aborted division produces no `done` pulse.

Configuration
REQ-023 The macro `DIV_ZERO_CHECK_EN` SHALL select divide-by-zero handling.
REQ-024 With `DIV_ZERO_CHECK_EN` defined, a start accepted with divisor=0 SHALL go straight to DONE on the next edge.
- Results: `div_zero`=1, `quotient`=7, `remainder`=`dividend`.
- `done` is high between edges 1 and 2.
REQ-025 With `DIV_ZERO_CHECK_EN` undefined, `div_zero` SHALL be tied to 0 and divisor=0 SHALL follow normal CALC flow.
- Subtraction of 0 never borrows, so the REQ-014 guard ends the operation with `quotient`=7, `remainder`=`dividend`.

Verification
REQ-026 Normal case: start, 7/2 -> `quotient`=3, `remainder`=1, `done` high between edges 4 and 5, `busy` high edges 0..5.
REQ-027 Divisor larger than dividend: start, 5/7 -> `quotient`=0, `remainder`=5, `done` high between edges 1 and 2.
REQ-028 Saturation boundary: start, 7/1 -> `quotient`=7, `remainder`=0, `done` high between edges 8 and 9.
REQ-029 Divide by zero: start, 6/0.
- Macro defined -> `div_zero`=1, `quotient`=7, `remainder`=6, `done` between edges 1 and 2.
- Macro undefined -> `div_zero`=0, `quotient`=7, `remainder`=6, `done` between edges 8 and 9.
REQ-030 Start while busy: start 6/3, then start 7/1 at edge 2.
- Second start ignored; result `quotient`=2, `remainder`=0.
- A start on the cycle after `done` is accepted.
REQ-031 Reset mid-operation: start 7/1, then `reset_`=0 at edge 3.
- At edge 3: all outputs 0, state IDLE, no `done` pulse.
- A following start 4/2 -> `quotient`=2, `remainder`=0.
